// File: rtl/mem_pkg.sv
// mem_pkg: shared size/direction codes, FSM states and lane-mask helper for mem_responder
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        return (sz == SZ_BYTE) ? 4'b0001 : (sz == SZ_HALF) ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: MOV/MOC memory handshake bus; Misaligned exists only with MEM_ALIGN_CHK_EN
interface mem_responder_if #(parameter int AW = 32);
    logic MOV;
    logic ReadWrite;
    logic [1:0] DataSize;
    logic [AW-1:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic MOC;
`ifdef MEM_ALIGN_CHK_EN
    logic Misaligned;
`endif
    modport master(output MOV, ReadWrite, DataSize, Address, DataIn, input DataOut, MOC
`ifdef MEM_ALIGN_CHK_EN
        , Misaligned
`endif
    );
    modport slave(input MOV, ReadWrite, DataSize, Address, DataIn, output DataOut, MOC
`ifdef MEM_ALIGN_CHK_EN
        , Misaligned
`endif
    );
endinterface

// File: rtl/mem_byte_array.sv
// mem_byte_array: DEPTH x 8 RAM, 4 byte-lane writes and a 4-byte big-endian read, addresses wrap
module mem_byte_array #(
    parameter int DEPTH = 256,
    localparam int AWM = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic [3:0] we,
    input  logic [AWM-1:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [7:0] mem [DEPTH];
    // lane i holds byte addr+i (modulo DEPTH), most significant byte in lane 0
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr + AWM'(i)] <= wdata[31-8*i -: 8];
    for (genvar i = 0; i < 4; i++) begin : g_rd
        assign rdata[31-8*i -: 8] = mem[addr + AWM'(i)];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory side of the MOV/MOC four-phase handshake; MEM_ALIGN_CHK_EN adds misalignment reporting
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int AW = 32
) (
    input logic clk,
    input logic reset,
    mem_responder_if.slave bus
);
    localparam int AWM = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    state_t state;
    logic [CW-1:0] cnt;
    logic [AWM-1:0] a, a_eff;
    logic [AW-1:0] addr_in;
    logic [31:0] d, wdata, rdata, rd_val, dout;
    logic [1:0] sz;
    logic [3:0] we;
    logic rw, fire, mis, moc;
    assign addr_in = bus.Address;
    assign fire = state == BUSY && bus.MOV && cnt == '0;
`ifdef MEM_ALIGN_CHK_EN
    logic mis_q;
    assign mis = (sz == SZ_HALF && a[0]) || (sz != SZ_BYTE && sz != SZ_HALF && a[1:0] != 2'b00);
    assign a_eff = a;
    assign bus.Misaligned = mis_q;
`else
    assign mis = 1'b0;
    assign a_eff = (sz == SZ_BYTE) ? a : (sz == SZ_HALF) ? {a[AWM-1:1], 1'b0} : {a[AWM-1:2], 2'b00};
`endif
    assign wdata = (sz == SZ_BYTE) ? {d[7:0], 24'h0} : (sz == SZ_HALF) ? {d[15:0], 16'h0} : d;
    assign we = (fire && !reset && rw == RW_WRITE && !mis) ? lane_mask(sz) : 4'b0000;
    assign rd_val = mis ? 32'h0 : (sz == SZ_BYTE) ? {24'h0, rdata[31:24]} :
                    (sz == SZ_HALF) ? {16'h0, rdata[31:16]} : rdata;
    assign bus.DataOut = dout;
    assign bus.MOC = moc;

    mem_byte_array #(.DEPTH(DEPTH)) u_ram (
        .clk(clk),
        .we(we),
        .addr(a_eff),
        .wdata(wdata),
        .rdata(rdata)
    );

    // handshake FSM: latch request, count wait cycles, complete access, hold MOC until MOV drops
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            moc <= 1'b0;
            dout <= 32'h0;
`ifdef MEM_ALIGN_CHK_EN
            mis_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.MOV) begin
                    state <= BUSY;
                    a <= AWM'(addr_in);
                    d <= bus.DataIn;
                    rw <= bus.ReadWrite;
                    sz <= bus.DataSize;
                    cnt <= CW'(WAIT_CYCLES);
                end
                BUSY: if (!bus.MOV) state <= IDLE;
                else if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= DONE;
                    moc <= 1'b1;
                    if (rw == RW_READ) dout <= rd_val;
`ifdef MEM_ALIGN_CHK_EN
                    mis_q <= mis;
`endif
                end
                default: if (!bus.MOV) begin
                    state <= IDLE;
                    moc <= 1'b0;
`ifdef MEM_ALIGN_CHK_EN
                    mis_q <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed MOV/MOC handshake tests against a byte-array model, per-cycle output compare
module tb_mem_responder;
    localparam int W = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    bit en = 1'b0;
    logic exp_moc = 1'b0;
    logic [31:0] exp_dout = 32'h0;
    logic exp_mis = 1'b0;
    logic [7:0] mm [256];
    int lat;
    logic mis_seen;

    mem_responder_if #(.AW(32)) bus();

    mem_responder #(.DEPTH(256), .WAIT_CYCLES(W), .AW(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle once reset has been applied: outputs must match the model
    always @(negedge clk) if (en) begin
        chk("moc", {31'h0, bus.MOC}, {31'h0, exp_moc});
        chk("dataout", bus.DataOut, exp_dout);
`ifdef MEM_ALIGN_CHK_EN
        chk("misaligned", {31'h0, bus.Misaligned}, {31'h0, exp_mis});
`endif
    end

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHK_EN
        return (addr % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_addr(input logic [1:0] sz, input logic [31:0] addr);
        int x = int'(addr % 256);
`ifdef MEM_ALIGN_CHK_EN
        return x;
`else
        return x - (x % nbytes(sz));
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sz, input logic [31:0] addr);
        logic [31:0] v = 32'h0;
        if (m_mis(sz, addr)) return 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            v = (v << 8) | 32'(mm[(m_addr(sz, addr) + i) % 256]);
        return v;
    endfunction

    task automatic m_write(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        int n = nbytes(sz);
        if (m_mis(sz, addr)) return;
        for (int i = 0; i < n; i++)
            mm[(m_addr(sz, addr) + i) % 256] = 8'(data >> (8 * (n - 1 - i)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        bus.MOV = 1'b1;
        bus.ReadWrite = rw;
        bus.DataSize = sz;
        bus.Address = addr;
        bus.DataIn = data;
    endtask

    // full request: MOC expected exactly W+1 edges after MOV is sampled, held two extra cycles, then released
    task automatic access(input logic rw, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                          output int l, output logic ms);
        l = 0;
        ms = 1'b0;
        drive(rw, sz, addr, data);
        tick();
        for (int k = 1; k <= W + 1; k++) begin
            tick();
            if (k == W + 1) begin
                exp_moc = 1'b1;
                exp_mis = m_mis(sz, addr);
                if (rw) exp_dout = m_read(sz, addr);
                else m_write(sz, addr, data);
            end
            if (bus.MOC === 1'b1 && l == 0) begin
                l = k;
                ms = exp_mis;
            end
        end
        tick();
        tick();
        bus.MOV = 1'b0;
        tick();
        exp_moc = 1'b0;
        exp_mis = 1'b0;
        tick();
    endtask

    initial begin
        bus.MOV = 1'b0;
        bus.ReadWrite = 1'b0;
        bus.DataSize = 2'b00;
        bus.Address = 32'h0;
        bus.DataIn = 32'h0;
        tick();
        en = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_moc", {31'h0, bus.MOC}, 32'h0);
        chk("reset_dout", bus.DataOut, 32'h0);

        access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, lat, mis_seen);
        chk("latency", 32'(lat), 32'd3);
        access(1'b1, 2'b10, 32'h10, 32'h0, lat, mis_seen);
        chk("rd_word_10", bus.DataOut, 32'hDEADBEEF);
        access(1'b1, 2'b00, 32'h11, 32'h0, lat, mis_seen);
        chk("rd_byte_11", bus.DataOut, 32'h000000AD);
        access(1'b1, 2'b01, 32'h12, 32'h0, lat, mis_seen);
        chk("rd_half_12", bus.DataOut, 32'h0000BEEF);

        access(1'b0, 2'b10, 32'h20, 32'h0, lat, mis_seen);
        access(1'b0, 2'b01, 32'h20, 32'h00001234, lat, mis_seen);
        access(1'b1, 2'b11, 32'h20, 32'h0, lat, mis_seen);
        chk("rd_word_20", bus.DataOut, 32'h12340000);

        access(1'b0, 2'b10, 32'h30, 32'h11223344, lat, mis_seen);
        drive(1'b0, 2'b10, 32'h30, 32'hCAFEF00D);
        tick();
        bus.MOV = 1'b0;
        repeat (6) tick();
        access(1'b1, 2'b10, 32'h30, 32'h0, lat, mis_seen);
        chk("rd_abort_30", bus.DataOut, 32'h11223344);

        access(1'b0, 2'b10, 32'h40, 32'h55667788, lat, mis_seen);
        drive(1'b0, 2'b10, 32'h40, 32'hA5A5A5A5);
        tick();
        reset = 1'b1;
        bus.MOV = 1'b0;
        tick();
        exp_dout = 32'h0;
        reset = 1'b0;
        chk("rst_busy_moc", {31'h0, bus.MOC}, 32'h0);
        chk("rst_busy_dout", bus.DataOut, 32'h0);
        repeat (4) tick();
        access(1'b1, 2'b10, 32'h40, 32'h0, lat, mis_seen);
        chk("rd_rst_40", bus.DataOut, 32'h55667788);

        access(1'b0, 2'b10, 32'h04, 32'h01020304, lat, mis_seen);
        access(1'b0, 2'b00, 32'h105, 32'h0000005A, lat, mis_seen);
        access(1'b1, 2'b00, 32'h05, 32'h0, lat, mis_seen);
        chk("rd_wrap_05", bus.DataOut, 32'h0000005A);
        access(1'b1, 2'b10, 32'h07, 32'h0, lat, mis_seen);
        chk("misalign_latency", 32'(lat), 32'd3);
`ifdef MEM_ALIGN_CHK_EN
        chk("misalign_dout", bus.DataOut, 32'h0);
        chk("misalign_flag", {31'h0, mis_seen}, 32'h1);
        access(1'b0, 2'b01, 32'h05, 32'h0000FFFF, lat, mis_seen);
        access(1'b1, 2'b10, 32'h04, 32'h0, lat, mis_seen);
        chk("misalign_nowrite", bus.DataOut, 32'h015A0304);
`else
        chk("align_word_07", bus.DataOut, 32'h015A0304);
        access(1'b1, 2'b01, 32'h07, 32'h0, lat, mis_seen);
        chk("align_half_07", bus.DataOut, 32'h00000304);
`endif
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
